// File: rtl/morse_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : morse_pkg                                          |
// | Description : Shared constants, FSM state encoding and one-hot   |
// |               <-> letter index conversion for the letter buffer. |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
package morse_pkg;

    localparam int LETTER_W = 26;
    localparam int IDX_W    = 5;
    localparam logic [IDX_W-1:0] BLANK_IDX = '0;

    typedef enum logic [0:0] {
        ST_LIVE   = 1'b0,
        ST_SCROLL = 1'b1
    } state_t;

    // One-hot letter (bit 25 = A ... bit 0 = Z) to index (1 = A ... 26 = Z).
    // Only meaningful when exactly one bit is set; zero input yields BLANK_IDX.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [LETTER_W-1:0] code);
        logic [IDX_W-1:0] idx;
        idx = BLANK_IDX;
        for (int b = 0; b < LETTER_W; b++) begin
            if (code[b]) begin
                idx = IDX_W'(LETTER_W - b);
            end
        end
        return idx;
    endfunction

    // Index back to one-hot; BLANK_IDX or out-of-range indices decode to all zeros.
    function automatic logic [LETTER_W-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [LETTER_W-1:0] code;
        code = '0;
        for (int b = 0; b < LETTER_W; b++) begin
            if (int'(idx) == (LETTER_W - b)) begin
                code[b] = 1'b1;
            end
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/morse_letter_buffer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : morse_letter_buffer_if                             |
// | Description : Strobe inputs and display/status outputs of the    |
// |               Morse letter history buffer.                       |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
interface morse_letter_buffer_if #(
    parameter int DEPTH = 16
) ();
    import morse_pkg::*;

    logic [LETTER_W-1:0]       letter_code;
    logic                      letter_done;
    logic                      clear;
    logic                      scroll_back;
    logic                      scroll_fwd;
    logic [LETTER_W-1:0]       SSD3;
    logic [LETTER_W-1:0]       SSD2;
    logic [LETTER_W-1:0]       SSD1;
    logic [LETTER_W-1:0]       SSD0;
    logic [$clog2(DEPTH):0]    count;
    logic                      live;
    logic                      err;

    modport master (
        output letter_code, letter_done, clear, scroll_back, scroll_fwd,
        input  SSD3, SSD2, SSD1, SSD0, count, live, err
    );

    modport slave (
        input  letter_code, letter_done, clear, scroll_back, scroll_fwd,
        output SSD3, SSD2, SSD1, SSD0, count, live, err
    );

endinterface
`default_nettype wire

// File: rtl/morse_letter_encoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : morse_letter_encoder                               |
// | Description : One-hot letter code to 5-bit index, with a valid   |
// |               flag that is high only when exactly one bit is set.|
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module morse_letter_encoder
    import morse_pkg::*;
(
    input  wire logic [LETTER_W-1:0] i_letter_code,
    output logic      [IDX_W-1:0]    o_idx,
    output logic                     o_valid
);

    // Non-zero and clearing the lowest set bit leaves nothing: a single bit.
    always_comb begin
        o_idx   = onehot_to_idx(i_letter_code);
        o_valid = (i_letter_code != '0) &&
                  ((i_letter_code & (i_letter_code - LETTER_W'(1))) == '0);
    end

endmodule
`default_nettype wire

// File: rtl/morse_letter_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : morse_letter_buffer                                |
// | Description : Circular history of decoded Morse letters with a   |
// |               four-digit scrollable view (LIVE / SCROLL).        |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module morse_letter_buffer
    import morse_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  wire logic            board_clk,
    input  wire logic            Reset,
    morse_letter_buffer_if.slave bus
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_DIGITS = 4;
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_VIEW    = c_CNT_W'(c_DIGITS);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [IDX_W-1:0]    r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  r_offset;
    state_t              r_state;
    logic                r_live;
    logic                r_err;
    logic [LETTER_W-1:0] r_ssd [c_DIGITS];

    logic [c_PTR_W-1:0]  w_wr_ptr_nxt;
    logic [c_CNT_W-1:0]  w_count_nxt;
    logic [c_CNT_W-1:0]  w_offset_nxt;
    state_t              w_state_nxt;
    logic                w_err_nxt;
    logic                w_we;
    logic [IDX_W-1:0]    w_enc_idx;
    logic                w_enc_valid;
    logic [c_PTR_W-1:0]  w_rd_ptr [c_DIGITS];
    logic [IDX_W-1:0]    w_rd_idx [c_DIGITS];
    logic [LETTER_W-1:0] w_ssd_nxt [c_DIGITS];

    morse_letter_encoder u_encoder (
        .i_letter_code (bus.letter_code),
        .o_idx         (w_enc_idx),
        .o_valid       (w_enc_valid)
    );

    // Next-state decision with strict priority clear > letter > back > forward.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_count_nxt  = r_count;
        w_offset_nxt = r_offset;
        w_state_nxt  = r_state;
        w_err_nxt    = 1'b0;
        w_we         = 1'b0;
        if (bus.clear) begin
            w_wr_ptr_nxt = '0;
            w_count_nxt  = '0;
            w_offset_nxt = '0;
            w_state_nxt  = ST_LIVE;
        end else if (bus.letter_done) begin
            if (w_enc_valid) begin
                w_we         = 1'b1;
                w_wr_ptr_nxt = r_wr_ptr + c_PTR_ONE;
                if (r_count != c_DEPTH) begin
                    w_count_nxt = r_count + c_CNT_ONE;
                end
                // Keep a scrolled view pinned on the same letters while room remains.
                if ((r_state == ST_SCROLL) && ((r_offset + c_VIEW) < c_DEPTH)) begin
                    w_offset_nxt = r_offset + c_CNT_ONE;
                end
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (bus.scroll_back) begin
            // In LIVE the offset is 0, so this same test is "more than four stored".
            if ((r_offset + c_VIEW) < r_count) begin
                w_offset_nxt = r_offset + c_CNT_ONE;
                w_state_nxt  = ST_SCROLL;
            end
        end else if (bus.scroll_fwd) begin
            if (r_state == ST_SCROLL) begin
                w_offset_nxt = r_offset - c_CNT_ONE;
                if (r_offset == c_CNT_ONE) begin
                    w_state_nxt = ST_LIVE;
                end
            end
        end
    end

    // Digit contents for the next view; a letter written this edge is forwarded.
    always_comb begin
        for (int k = 0; k < c_DIGITS; k++) begin
            w_rd_ptr[k] = w_wr_ptr_nxt - c_PTR_ONE - w_offset_nxt[c_PTR_W-1:0] - c_PTR_W'(k);
            if (w_we && (w_rd_ptr[k] == r_wr_ptr)) begin
                w_rd_idx[k] = w_enc_idx;
            end else begin
                w_rd_idx[k] = r_mem[w_rd_ptr[k]];
            end
            if ((w_offset_nxt + c_CNT_W'(k)) < w_count_nxt) begin
                w_ssd_nxt[k] = idx_to_onehot(w_rd_idx[k]);
            end else begin
                w_ssd_nxt[k] = '0;
            end
        end
    end

    // Letter storage; contents need no reset because count gates visibility.
    always_ff @(posedge board_clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= w_enc_idx;
        end
    end

    // FSM, pointers and registered outputs.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= ST_LIVE;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_offset <= '0;
            r_live   <= 1'b1;
            r_err    <= 1'b0;
            for (int k = 0; k < c_DIGITS; k++) begin
                r_ssd[k] <= '0;
            end
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_count  <= w_count_nxt;
            r_offset <= w_offset_nxt;
            r_live   <= (w_state_nxt == ST_LIVE);
            r_err    <= w_err_nxt;
            for (int k = 0; k < c_DIGITS; k++) begin
                r_ssd[k] <= w_ssd_nxt[k];
            end
        end
    end

    assign bus.SSD0  = r_ssd[0];
    assign bus.SSD1  = r_ssd[1];
    assign bus.SSD2  = r_ssd[2];
    assign bus.SSD3  = r_ssd[3];
    assign bus.count = r_count;
    assign bus.live  = r_live;
    assign bus.err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_morse_letter_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_morse_letter_buffer                             |
// | Description : Directed plus random stimulus for the Morse letter |
// |               buffer against a queue-based history model.        |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module tb_morse_letter_buffer;

    localparam int DEPTH = 16;

    logic board_clk = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad   = 0;

    // Reference model: oldest letter at front, newest at back; off = view offset.
    int   hist[$];
    int   off;
    logic exp_err;

    morse_letter_buffer_if #(.DEPTH(DEPTH)) bus_if ();

    morse_letter_buffer #(.DEPTH(DEPTH)) dut (
        .board_clk (board_clk),
        .Reset     (Reset),
        .bus       (bus_if)
    );

    always #5 board_clk = ~board_clk;

    function automatic logic [25:0] letter(input int idx);
        logic [25:0] v;
        v = '0;
        if (idx >= 1 && idx <= 26) v[26 - idx] = 1'b1;
        return v;
    endfunction

    function automatic int code_to_idx(input logic [25:0] code);
        int r;
        r = 0;
        for (int b = 0; b < 26; b++) if (code[b]) r = 26 - b;
        return r;
    endfunction

    function automatic logic [25:0] digit(input int k);
        case (k)
            0: return bus_if.SSD0;
            1: return bus_if.SSD1;
            2: return bus_if.SSD2;
            default: return bus_if.SSD3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        int n;
        logic [31:0] e;
        n = hist.size();
        chk({where, ":count"}, 32'(bus_if.count), 32'(n));
        chk({where, ":live"}, 32'(bus_if.live), 32'(off == 0));
        chk({where, ":err"}, 32'(bus_if.err), 32'(exp_err));
        for (int k = 0; k < 4; k++) begin
            e = (off + k < n) ? 32'(letter(hist[n - 1 - off - k])) : 32'd0;
            chk($sformatf("%s:ssd%0d", where, k), 32'(digit(k)), e);
        end
    endtask

    task automatic model_update(input logic cl, input logic ld, input logic [25:0] code,
                                input logic sb, input logic sf);
        exp_err = 1'b0;
        if (cl) begin
            hist.delete();
            off = 0;
        end else if (ld) begin
            if ($countones(code) == 1) begin
                hist.push_back(code_to_idx(code));
                if (hist.size() > DEPTH) void'(hist.pop_front());
                if (off > 0 && off + 4 < DEPTH) off++;
            end else begin
                exp_err = 1'b1;
            end
        end else if (sb) begin
            if (off + 4 < hist.size()) off++;
        end else if (sf) begin
            if (off > 0) off--;
        end
    endtask

    task automatic step(input logic cl, input logic ld, input logic [25:0] code,
                        input logic sb, input logic sf);
        @(negedge board_clk);
        bus_if.clear       = cl;
        bus_if.letter_done = ld;
        bus_if.letter_code = code;
        bus_if.scroll_back = sb;
        bus_if.scroll_fwd  = sf;
        @(posedge board_clk);
        model_update(cl, ld, code, sb, sf);
        #1;
        bus_if.clear       = 1'b0;
        bus_if.letter_done = 1'b0;
        bus_if.scroll_back = 1'b0;
        bus_if.scroll_fwd  = 1'b0;
        check_all("step");
    endtask

    task automatic send(input int idx);
        step(1'b0, 1'b1, letter(idx), 1'b0, 1'b0);
    endtask

    initial begin
        logic [25:0] rc;
        int          sel;
        bus_if.letter_code = '0;
        bus_if.letter_done = 1'b0;
        bus_if.clear       = 1'b0;
        bus_if.scroll_back = 1'b0;
        bus_if.scroll_fwd  = 1'b0;
        off     = 0;
        exp_err = 1'b0;
        Reset   = 1'b1;
        repeat (2) @(posedge board_clk);
        #1;
        check_all("reset");
        @(negedge board_clk);
        Reset = 1'b0;

        // S, O, S
        send(19); send(15); send(19);
        chk("sos_ssd3", 32'(bus_if.SSD3), 32'd0);
        chk("sos_ssd2", 32'(bus_if.SSD2), 32'(letter(19)));
        chk("sos_ssd1", 32'(bus_if.SSD1), 32'(letter(15)));
        chk("sos_ssd0", 32'(bus_if.SSD0), 32'(letter(19)));
        chk("sos_count", 32'(bus_if.count), 32'd3);
        chk("sos_live", 32'(bus_if.live), 32'd1);

        // A..R overfills the 16-entry history
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 1; i <= 18; i++) send(i);
        chk("full_count", 32'(bus_if.count), 32'd16);
        chk("full_ssd3", 32'(bus_if.SSD3), 32'(letter(15)));
        chk("full_ssd0", 32'(bus_if.SSD0), 32'(letter(18)));
        repeat (12) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("back12_ssd3", 32'(bus_if.SSD3), 32'(letter(3)));
        chk("back12_ssd2", 32'(bus_if.SSD2), 32'(letter(4)));
        chk("back12_ssd1", 32'(bus_if.SSD1), 32'(letter(5)));
        chk("back12_ssd0", 32'(bus_if.SSD0), 32'(letter(6)));
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("back13_ssd3", 32'(bus_if.SSD3), 32'(letter(3)));
        chk("back13_ssd0", 32'(bus_if.SSD0), 32'(letter(6)));
        chk("back13_live", 32'(bus_if.live), 32'd0);

        // Rejected letters: none set, two set
        step(1'b0, 1'b1, 26'd0, 1'b0, 1'b0);
        chk("err_zero", 32'(bus_if.err), 32'd1);
        chk("err_zero_count", 32'(bus_if.count), 32'd16);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("err_drop", 32'(bus_if.err), 32'd0);
        step(1'b0, 1'b1, 26'h300_0000, 1'b0, 1'b0);
        chk("err_two", 32'(bus_if.err), 32'd1);
        chk("err_two_count", 32'(bus_if.count), 32'd16);

        // Frozen view while scrolled, then return to LIVE
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) send(i);
        repeat (2) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("off2_ssd0", 32'(bus_if.SSD0), 32'(letter(6)));
        send(5);
        chk("frozen_ssd0", 32'(bus_if.SSD0), 32'(letter(6)));
        chk("frozen_ssd3", 32'(bus_if.SSD3), 32'(letter(3)));
        repeat (3) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("fwd_live", 32'(bus_if.live), 32'd1);
        chk("fwd_ssd0", 32'(bus_if.SSD0), 32'(letter(5)));
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Priority collisions
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b1, letter(26), 1'b1, 1'b0);
        step(1'b1, 1'b1, letter(1), 1'b1, 1'b1);
        chk("clr_ld_count", 32'(bus_if.count), 32'd0);
        chk("clr_ld_ssd0", 32'(bus_if.SSD0), 32'd0);
        for (int i = 0; i < 4; i++) send(i + 10);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("back_le4_live", 32'(bus_if.live), 32'd1);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       rc = letter(int'($urandom_range(1, 26)));
            else if (sel == 8) rc = '0;
            else               rc = 26'($urandom);
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 4), rc,
                 ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3));
        end

        // Asynchronous reset while scrolled
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) send(i);
        repeat (3) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("pre_reset_live", 32'(bus_if.live), 32'd0);
        @(negedge board_clk);
        #2;
        Reset = 1'b1;
        #1;
        hist.delete();
        off     = 0;
        exp_err = 1'b0;
        check_all("async_reset");
        @(negedge board_clk);
        Reset = 1'b0;
        send(7);
        chk("post_reset_ssd0", 32'(bus_if.SSD0), 32'(letter(7)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/morse_letter_buffer.md
MORSE_LETTER_BUFFER -- requirements
Module: morse_letter_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, history capacity in letters (power of two, ≥ 4).
REQ-002 SHALL have port board_clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port letter_code  input  26  one-hot decoded letter, bit 25 = A … bit 0 = Z.
REQ-005 SHALL have port letter_done  input  1  one-cycle strobe: letter_code is complete and valid to sample.
REQ-006 SHALL have port clear  input  1  one-cycle strobe: empty the history.
REQ-007 SHALL have port scroll_back  input  1  one-cycle strobe (debounced SCEN): view one letter older.
REQ-008 SHALL have port scroll_fwd  input  1  one-cycle strobe: view one letter newer.
REQ-009 SHALL have ports SSD3, SSD2, SSD1, SSD0  output  26 each  one-hot digit codes, 26'b0 = blank; SSD0 rightmost (newest in view).
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  number of stored letters, 0..DEPTH.
REQ-011 SHALL have port live  output  1  high in LIVE state.
REQ-012 SHALL have port err  output  1  one-cycle pulse on rejected letter.

Function
REQ-013 Storage SHALL be a DEPTH-entry circular buffer of 5-bit indices (1=A … 26=Z), with write pointer wr_ptr wrapping modulo DEPTH.
REQ-014 On letter_done with exactly one letter_code bit set, the block SHALL write its index at wr_ptr, increment wr_ptr, and increment count, saturating at DEPTH.
REQ-015 When count = DEPTH, a new letter SHALL overwrite the oldest entry; count stays DEPTH.
REQ-016 On letter_done with zero or multiple bits set, the block SHALL NOT store anything and SHALL pulse err high for exactly the next cycle.
REQ-017 Display mapping: digit k (SSD0 = k0 … SSD3 = k3) SHALL show entry (wr_ptr−1−offset−k) mod DEPTH, decoded to one-hot, if offset+k < count; otherwise blank.
REQ-018 SSDn, count, live and err SHALL reflect an event in the cycle immediately after the capturing edge; they are driven from registers with no further pipeline.
REQ-019 The FSM SHALL have two states, LIVE (offset = 0) and SCROLL (offset ≥ 1).
REQ-020 LIVE→SCROLL on scroll_back when count > 4: offset becomes 1; scroll_back with count ≤ 4 SHALL be ignored.
REQ-021 In SCROLL, scroll_back SHALL increment offset only while offset+4 < count; otherwise it SHALL be ignored.
REQ-022 In SCROLL, scroll_fwd SHALL decrement offset; on reaching 0 the FSM SHALL enter LIVE.
REQ-023 In LIVE, scroll_fwd SHALL be ignored.
REQ-024 In SCROLL, a stored letter SHALL increment offset (frozen view) while offset+4 < DEPTH; otherwise offset holds and the view advances.
REQ-025 Priority in one cycle SHALL be: clear > letter_done > scroll_back > scroll_fwd; lower-priority strobes in that cycle are dropped.
REQ-026 clear SHALL set count = 0, wr_ptr = 0 and offset = 0, enter LIVE, and blank all digits; stored data need not be zeroed.
REQ-027 Simultaneous scroll_back and scroll_fwd without letter_done or clear SHALL apply scroll_back only.

Reset
REQ-028 Reset SHALL asynchronously force LIVE, wr_ptr = 0, count = 0, offset = 0 and err = 0, with SSD0–SSD3 = 26'b0 and live = 1.
REQ-029 Reset asserted mid-operation SHALL discard all history; there is no partial retention.

Structure
REQ-030 Package morse_pkg SHALL hold LETTER_W = 26, IDX_W = 5, BLANK_IDX = 0, the FSM state encoding, and the one-hot↔index conversion functions.
REQ-031 One sub-module, morse_letter_encoder, SHALL convert one-hot to index plus a valid flag (exactly one bit set); decoding back to one-hot uses the package function.

Verification
REQ-032 Reset, then letter_done with codes S, O, S → next cycle SSD2 = S, SSD1 = O, SSD0 = S, SSD3 = blank, count = 3, live = 1.
REQ-033 Store 18 letters A..R with DEPTH = 16 → count = 16; SSD3..SSD0 = O, P, Q, R; scroll_back ×12 → SSD3..SSD0 = C, D, E, F; a 13th scroll_back is ignored.
REQ-034 letter_done with letter_code = 0, then with bits 25 and 24 set → err pulses one cycle each; count unchanged.
REQ-035 In SCROLL with offset = 2, letter_done E → display unchanged and offset = 3; scroll_fwd ×3 → live = 1, SSD0 = E.
REQ-036 clear and letter_done in the same cycle → count = 0, all digits blank; Reset asserted during SCROLL → outputs at reset values asynchronously.
